// File: rtl/isa_sequencer.sv
// Multicycle FETCH/EXEC sequencer for the 9-bit ISA core: PC, IR, PREP tracking, BEQ redirect, HALT.
// Optional retired-instruction counter enabled by defining ISA_SEQ_CYCLE_COUNT_EN.
module isa_sequencer #(
    parameter int unsigned PCW        = 8,
    parameter int unsigned IW         = 9,
    parameter int unsigned START_ADDR = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [IW-1:0]  instr,
    input  logic           alu_zero,
    input  logic [PCW-1:0] branch_target,
    output logic [PCW-1:0] pc,
    output logic [IW-1:0]  ir,
    output logic           prep_active,
    output logic           exec_en,
    output logic           busy,
    output logic           done,
    output logic           illegal,
    output logic [15:0]    cycle_count
);

    localparam logic [PCW-1:0] START_PC = PCW'(START_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t     state;
    logic [2:0] fetch_op;
    logic [2:0] exec_op;
    logic       fetch_illegal;
    logic       exec_halt;
    logic       exec_taken;
    logic       start_accept;

    assign fetch_op      = instr[IW-1 -: 3];
    assign exec_op       = ir[IW-1 -: 3];
    // Illegal is decided while fetching so the pulse lines up with exec_en.
    assign fetch_illegal = prep_active ? (fetch_op == 3'b111) : (fetch_op == 3'b110);
    assign exec_halt     = !prep_active && (exec_op == 3'b111);
    assign exec_taken    = prep_active && (exec_op == 3'b001) && alu_zero;
    assign start_accept  = start && ((state == S_IDLE) || (state == S_HALT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= START_PC;
            ir          <= '0;
            prep_active <= 1'b0;
            exec_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            exec_en <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state       <= S_FETCH;
                        pc          <= START_PC;
                        prep_active <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir      <= instr;
                    state   <= S_EXEC;
                    exec_en <= 1'b1;
                    illegal <= fetch_illegal;
                end
                S_EXEC: begin
                    if (exec_halt) begin
                        state <= S_HALT;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                        pc    <= exec_taken ? branch_target : pc + PCW'(1);
                    end
                    // PREP sets the mode; only PSFT/PXOR keep it alive.
                    if (!prep_active) begin
                        prep_active <= (exec_op == 3'b000);
                    end else begin
                        prep_active <= (exec_op == 3'b101) || (exec_op == 3'b110);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ISA_SEQ_CYCLE_COUNT_EN
    // Saturating count of EXEC cycles since the last accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (start_accept) begin
            cycle_count <= '0;
        end else if ((state == S_EXEC) && (cycle_count != 16'hFFFF)) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end
`else
    assign cycle_count = 16'd0;
`endif

endmodule
